// File: rtl/pow_5_pkg.sv
// Shared types and constants for the x^5 stream front-end.
// Optional statistics port is enabled with POW5_STREAM_STATS_EN.
package pow_5_pkg;

    localparam int POW5_ENGINE_LATENCY = 5;
    localparam int POW5_DEFAULT_WIDTH  = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } pow5_state_e;

    // Watchdog counter width able to hold values 0..timeout.
    function automatic int pow5_wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pow_5_operand_fifo.sv
// Show-ahead operand FIFO with wrap-around pointers carrying an extra MSB
// to distinguish full from empty.
module pow_5_operand_fifo
    import pow_5_pkg::*;
#(
    parameter int WIDTH      = POW5_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    // Head is read combinationally so the consumer sees it without a bubble.
    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/pow_5_stream_ctrl.sv
// Valid/ready front-end for the multi-cycle x^5 engine: one op in flight,
// watchdog abort, held result register. POW5_STREAM_STATS_EN adds op_count.
module pow_5_stream_ctrl
    import pow_5_pkg::*;
#(
    parameter int WIDTH      = POW5_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             eng_run,
    output logic [WIDTH-1:0] eng_n,
    input  logic             eng_ready,
    input  logic [WIDTH-1:0] eng_result,
    output logic             err_timeout
`ifdef POW5_STREAM_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    // A watchdog shorter than the engine would abort every operation.
    localparam int EFF_TIMEOUT = (TIMEOUT > POW5_ENGINE_LATENCY) ? TIMEOUT
                                                                 : POW5_ENGINE_LATENCY + 1;
    localparam int WD_W = pow5_wd_width(EFF_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(EFF_TIMEOUT - 1);

    pow5_state_e      state_q;
    logic             eng_run_q;
    logic [WIDTH-1:0] eng_n_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WD_W-1:0]  wd_q;
    logic             err_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_head;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    // Issue only with the output register free, so an engine result always has a home.
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !out_valid_q;

    pow_5_operand_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push_i    (fifo_push),
        .wr_data_i (in_n),
        .pop_i     (fifo_pop),
        .head_o    (fifo_head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            eng_run_q   <= 1'b0;
            eng_n_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        eng_n_q   <= fifo_head;
                        eng_run_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_run_q <= 1'b0;
                    wd_q      <= '0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (eng_ready) begin
                        out_data_q  <= eng_result;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (wd_q == WD_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    eng_run_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign eng_run     = eng_run_q;
    assign eng_n       = eng_n_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign err_timeout = err_q;

`ifdef POW5_STREAM_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_count_q <= '0;
        end else if (out_valid_q && out_ready && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_pow_5_stream_ctrl.sv
// Directed bench for pow_5_stream_ctrl with a behavioural 5-cycle x^5 engine
// (switchable to a stub that never answers).
module tb_pow_5_stream_ctrl;

    localparam int W = 18;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_n = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         eng_run;
    logic [W-1:0] eng_n;
    logic         eng_ready;
    logic [W-1:0] eng_result;
    logic         err_timeout;
`ifdef POW5_STREAM_STATS_EN
    logic [15:0]  op_count;
`endif

    always #5 clock = ~clock;

    pow_5_stream_ctrl #(
        .WIDTH      (W),
        .FIFO_DEPTH (4),
        .TIMEOUT    (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_n        (in_n),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .eng_run     (eng_run),
        .eng_n       (eng_n),
        .eng_ready   (eng_ready),
        .eng_result  (eng_result),
        .err_timeout (err_timeout)
`ifdef POW5_STREAM_STATS_EN
        ,
        .op_count    (op_count)
`endif
    );

    // Engine: samples eng_run at an edge, pulses ready after the 4th following edge.
    logic         stub_mode = 1'b0;
    logic         stray = 1'b0;
    logic [2:0]   eng_cnt;
    logic         eng_rdy_m;
    logic [W-1:0] eng_res_m;

    function automatic logic [W-1:0] p5(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        for (int i = 0; i < 4; i++) r = r * x;
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            eng_cnt   <= '0;
            eng_rdy_m <= 1'b0;
            eng_res_m <= '0;
        end else begin
            eng_rdy_m <= 1'b0;
            if (eng_run) begin
                eng_cnt   <= 3'd4;
                eng_res_m <= p5(eng_n);
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 3'd1;
                if (eng_cnt == 3'd1 && !stub_mode) eng_rdy_m <= 1'b1;
            end
        end
    end

    assign eng_ready  = eng_rdy_m | stray;
    assign eng_result = eng_res_m;

    int           run_cnt = 0;
    int           viol = 0;
    logic [W-1:0] got_q[$];

    always @(posedge clock) begin
        if (reset_n) begin
            if (eng_run) run_cnt++;
            if (eng_run && out_valid) viol++;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                $display("out transfer: data=%0d", out_data);
            end
        end
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push(input logic [W-1:0] v);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_n     = v;
        while (!in_ready && k < 60) begin
            step();
            k++;
        end
        if (!in_ready) chk("push_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        $display("in transfer: n=%0d", v);
    endtask

    task automatic wait_results(input int n, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin
            step();
            k++;
        end
        chk(tag, got_q.size(), n);
    endtask

    logic [W-1:0] held;
    int           changes;
    int           runs0;
    int           k;

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_eng_run", eng_run, 0);
        chk("rst_eng_n", eng_n, 0);
        chk("rst_err", err_timeout, 0);
        reset_n = 1'b1;
        step();

        // 1: single op latency (accept E0 ... out_valid after E7)
        out_ready = 1'b1;
        push(18'd3);
        step();
        chk("t1_run_e1", eng_run, 1);
        chk("t1_eng_n", eng_n, 3);
        step();
        chk("t1_run_e2", eng_run, 0);
        repeat (4) step();
        chk("t1_valid_e6", out_valid, 0);
        step();
        chk("t1_valid_e7", out_valid, 1);
        chk("t1_data", out_data, 243);
        chk("t1_runs", run_cnt, 1);
        out_ready = 1'b0;

        // 2: back-to-back with result held so the FIFO fills after 4 pushes
        push(18'd2);
        push(18'd3);
        push(18'd4);
        push(18'd5);
        chk("t2_full", in_ready, 0);
        out_ready = 1'b1;
        push(18'd6);
        wait_results(6, "t2_count");
        chk("t2_r0", got_q[0], 243);
        chk("t2_r1", got_q[1], 32);
        chk("t2_r2", got_q[2], 243);
        chk("t2_r3", got_q[3], 1024);
        chk("t2_r4", got_q[4], 3125);
        chk("t2_r5", got_q[5], 7776);
        got_q.delete();

        // 3: wrap-around truncation
        push(18'h3FFFF);
        push(18'd1024);
        wait_results(2, "t3_count");
        chk("t3_allones", got_q[0], 18'h3FFFF);
        chk("t3_2pow50", got_q[1], 0);
        got_q.delete();

        // 4: backpressure for 30 cycles
        out_ready = 1'b0;
        push(18'd7);
        push(18'd8);
        push(18'd9);
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        chk("t4_valid", out_valid, 1);
        held    = out_data;
        runs0   = run_cnt;
        changes = 0;
        repeat (30) begin
            step();
            if (!out_valid || out_data !== held) changes++;
        end
        chk("t4_stable", changes, 0);
        chk("t4_held", held, 16807);
        chk("t4_no_run", run_cnt - runs0, 0);
        chk("t4_overlap", viol, 0);
        out_ready = 1'b1;
        wait_results(3, "t4_count");
        chk("t4_r0", got_q[0], 16807);
        chk("t4_r1", got_q[1], 32768);
        chk("t4_r2", got_q[2], 59049);
        got_q.delete();

        // 5: timeout with a silent engine, then stray ready in IDLE
        stub_mode = 1'b1;
        push(18'd10);
        repeat (9) step();
        chk("t5_err_e9", err_timeout, 0);
        step();
        chk("t5_err_e10", err_timeout, 1);
        chk("t5_no_valid", out_valid, 0);
        stub_mode = 1'b0;
        stray = 1'b1;
        step();
        stray = 1'b0;
        repeat (3) step();
        chk("t5_stray_valid", out_valid, 0);
        chk("t5_stray_count", got_q.size(), 0);
        push(18'd11);
        wait_results(1, "t5_count");
        chk("t5_next", got_q[0], 161051);
        chk("t5_sticky", err_timeout, 1);
        got_q.delete();

        // 6: asynchronous reset during WAIT
        push(18'd12);
        repeat (4) step();
        reset_n = 1'b0;
        #1;
        chk("t6_in_ready", in_ready, 1);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_eng_run", eng_run, 0);
        chk("t6_eng_n", eng_n, 0);
        chk("t6_err", err_timeout, 0);
        step();
        reset_n = 1'b1;
        step();
        got_q.delete();
        push(18'd2);
        wait_results(1, "t6_count");
        chk("t6_after", got_q[0], 32);
`ifdef POW5_STREAM_STATS_EN
        step();
        chk("stats_count", op_count, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
